// File: rtl/klein_serial_ctrl.sv
// Sequencer for the 8-bit serial KLEIN-80 datapath: LOAD (10 bytes), RUN (ROUNDS x PHASES), OUT (8 bytes).
// Optional define KLEIN_CTRL_ABORT_EN adds an `abort` input that returns the controller to IDLE.
module klein_serial_ctrl #(
  parameter int ROUNDS = 16,
  parameter int PHASES = 12
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
`ifdef KLEIN_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       in_ready,
  output logic       round0,
  output logic       round1,
  output logic [4:0] round,
  output logic [3:0] sels,
  output logic [4:0] selk,
  output logic       out_valid,
  output logic       done,
  output logic       err,
  output logic       busy
);

  localparam int PH_W = $clog2(PHASES);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

  state_t          state, state_n;
  logic [3:0]      cnt, cnt_n;
  logic [PH_W-1:0] ph, ph_n;
  logic [4:0]      rnd, rnd_n;
  logic            err_n, done_n;

  function automatic logic [3:0] sels_of(input logic [PH_W-1:0] p);
    logic [3:0] s;
    s[0] = (p >= PH_W'(8)) && (p <= PH_W'(11));
    s[1] = (p == PH_W'(0)) || (p == PH_W'(4));
    s[2] = (p == PH_W'(1)) || (p == PH_W'(5));
    s[3] = (p == PH_W'(2)) || (p == PH_W'(6));
    return s;
  endfunction

  function automatic logic [4:0] selk_of(input logic [PH_W-1:0] p);
    logic [4:0] k;
    k[0] = (p <= PH_W'(7));
    k[1] = (p == PH_W'(3)) || (p == PH_W'(7));
    k[2] = (p == PH_W'(8)) || (p == PH_W'(9));
    k[3] = (p == PH_W'(9)) || (p == PH_W'(10));
    k[4] = (p == PH_W'(9));
    return k;
  endfunction

  // Next-state logic; outputs are registered from these next values below.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ph_n    = ph;
    rnd_n   = rnd;
    err_n   = err;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = LOAD;
          cnt_n   = 4'd0;
          err_n   = 1'b0;
        end
      end
      LOAD: begin
        if (!in_valid) begin
          state_n = IDLE;
          cnt_n   = 4'd0;
          err_n   = 1'b1;
        end else if (cnt == 4'd9) begin
          state_n = RUN;
          cnt_n   = 4'd0;
          rnd_n   = 5'd1;
          ph_n    = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      RUN: begin
        if (ph == PH_W'(PHASES - 1)) begin
          ph_n = '0;
          if (rnd == 5'(ROUNDS)) begin
            state_n = OUT;
            cnt_n   = 4'd0;
            rnd_n   = 5'd0;
          end else begin
            rnd_n = rnd + 5'd1;
          end
        end else begin
          ph_n = ph + 1'b1;
        end
      end
      OUT: begin
        if (cnt == 4'd7) begin
          state_n = IDLE;
          cnt_n   = 4'd0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef KLEIN_CTRL_ABORT_EN
    // Abort wins over a same-cycle load underrun and never raises err/done.
    if (abort && (state != IDLE)) begin
      state_n = IDLE;
      cnt_n   = 4'd0;
      ph_n    = '0;
      rnd_n   = 5'd0;
      err_n   = err;
      done_n  = 1'b0;
    end
`endif
  end

  // State and registered output stage
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ph        <= '0;
      rnd       <= 5'd0;
      err       <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
      round0    <= 1'b0;
      round1    <= 1'b0;
      round     <= 5'd0;
      sels      <= 4'd0;
      selk      <= 5'd0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ph        <= ph_n;
      rnd       <= rnd_n;
      err       <= err_n;
      done      <= done_n;
      busy      <= (state_n != IDLE);
      in_ready  <= (state_n == IDLE) || (state_n == LOAD);
      round0    <= (state_n == LOAD) && (cnt_n < 4'd8);
      round1    <= (state_n == LOAD) && (cnt_n >= 4'd8);
      round     <= (state_n == RUN) ? rnd_n : 5'd0;
      sels      <= (state_n == RUN) ? sels_of(ph_n) : 4'd0;
      selk      <= (state_n == RUN) ? selk_of(ph_n) : 5'd0;
      out_valid <= (state_n == OUT);
    end
  end

endmodule
